// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage load/store initiator. Takes the access held in the MEM stage and
//   issues it on a request/grant/response bus with four byte lanes. It stalls
//   the pipeline until the transaction completes and returns sign- or
//   zero-extended load data to write-back.
//
//   Optional feature macro: MISALIGN_EXC_EN
//     defined   : a misaligned access makes no bus request. misalign pulses
//                 for one cycle and the FSM stays in IDLE.
//     undefined : the low address bits are forced to alignment and the access
//                 proceeds. misalign is tied to 0.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   ex_valid/load/store    MEM-stage access qualifiers (store wins over load)
//   ex_size, ex_unsigned   access size (00 B, 01 H, 1x W), zero-extend loads
//   ex_addr, ex_wdata      byte address, right-justified store data
//   stall                  freeze the pipeline this cycle
//   ld_valid, ld_data      load-result pulse and extended load data (held)
//   misalign               misaligned-access pulse (feature build only)
//   bus_req/we/addr/be/wdata   request side of the data bus
//   bus_gnt, bus_rvalid, bus_rdata  grant and read-response side
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32   // only 32 is supported: four byte lanes
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              ex_load,
   input  logic              ex_store,
   input  logic [1:0]        ex_size,
   input  logic              ex_unsigned,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   output logic              stall,
   output logic              ld_valid,
   output logic [DATA_W-1:0] ld_data,
   output logic              misalign,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

   state_e            state_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] ld_data_q;
   logic [1:0]        size_q;
   logic [1:0]        off_q;
   logic              uns_q;

   logic              access;
   logic              take;
   logic [1:0]        off_d;
   logic [3:0]        be_d;
   logic [DATA_W-1:0] wdata_d;
   logic [DATA_W-1:0] rsh;
   logic [DATA_W-1:0] ld_ext;

   assign access = ex_valid & (ex_load | ex_store);

`ifdef MISALIGN_EXC_EN
   logic mis_det;
   logic misalign_q;
   assign mis_det = ((ex_size == 2'b01) & ex_addr[0]) |
                    (ex_size[1] & (ex_addr[1:0] != 2'b00));
   assign take     = access & ~mis_det;
   assign misalign = misalign_q;
`else
   assign take     = access;
   assign misalign = 1'b0;
`endif

   // Lane placement. The registered offset is already aligned to the access
   // size, so a misaligned half/word without the exception feature is
   // serviced from the aligned lanes.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      off_d   = ex_addr[1:0];
      be_d    = 4'b1111;
      wdata_d = ex_wdata;
      case (ex_size)
         2'b00: begin
            be_d    = 4'b0001 << ex_addr[1:0];
            wdata_d = {4{ex_wdata[7:0]}};
         end
         2'b01: begin
            off_d   = {ex_addr[1], 1'b0};
            be_d    = 4'b0011 << {ex_addr[1], 1'b0};
            wdata_d = {2{ex_wdata[15:0]}};
         end
         default: off_d = 2'b00;
      endcase
   end

   // Load extraction from the returned word.
   assign rsh = bus_rdata >> {off_q, 3'b000};

   always_comb begin
      ld_ext = rsh;
      case (size_q)
         2'b00:   ld_ext = {{(DATA_W-8){~uns_q & rsh[7]}}, rsh[7:0]};
         2'b01:   ld_ext = {{(DATA_W-16){~uns_q & rsh[15]}}, rsh[15:0]};
         default: ld_ext = rsh;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         ld_data_q  <= '0;
         size_q     <= '0;
         off_q      <= '0;
         uns_q      <= 1'b0;
`ifdef MISALIGN_EXC_EN
         misalign_q <= 1'b0;
`endif
      end else begin
`ifdef MISALIGN_EXC_EN
         misalign_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (take) begin
                  we_q    <= ex_store;
                  addr_q  <= {ex_addr[ADDR_W-1:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
                  size_q  <= ex_size;
                  off_q   <= off_d;
                  uns_q   <= ex_unsigned;
                  state_q <= S_REQ;
               end
`ifdef MISALIGN_EXC_EN
               else if (access) begin
                  misalign_q <= 1'b1;
               end
`endif
            end
            // Response data arriving before the grant is not ours; only the
            // grant is looked at here.
            S_REQ: begin
               if (bus_gnt) state_q <= we_q ? S_DONE : S_RESP;
            end
            S_RESP: begin
               if (bus_rvalid) begin
                  ld_data_q <= ld_ext;
                  state_q   <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;   // S_DONE: one unstalled cycle
         endcase
      end
   end

   // stall is gated by rst_n so it drops the moment reset is asserted, even
   // while the MEM stage still presents an access.
   assign stall     = rst_n & (((state_q == S_IDLE) & take) |
                               (state_q == S_REQ) | (state_q == S_RESP));
   assign bus_req   = (state_q == S_REQ);
   assign ld_valid  = (state_q == S_DONE) & ~we_q;
   assign ld_data   = ld_data_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;

endmodule
